// File: rtl/sata_link_write_arbiter.sv
// rtl/sata_link_write_arbiter.sv - two-requester round-robin arbiter for the SATA link write port
// Optional BUSY watchdog with SYNC escape is compiled in by SATA_WR_ARB_WATCHDOG_EN.
module sata_link_write_arbiter #(
  parameter logic [31:0] WATCHDOG_CYCLES = 32'd65536
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic [23:0] size0,
  input  logic [23:0] size1,
  input  logic [31:0] data0,
  input  logic [31:0] data1,
  output logic        strobe0,
  output logic        strobe1,
  output logic        done0,
  output logic        done1,
  output logic        err0,
  output logic        err1,
  output logic [1:0]  grant,
  output logic        busy,
  input  logic        link_idle,
  output logic        write_start,
  output logic [31:0] write_size,
  output logic [31:0] write_data,
  input  logic        write_strobe,
  input  logic        write_finished,
  input  logic        xmit_error,
  output logic        send_sync_escape
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_BUSY  = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_ABORT = 3'd4;

  logic [2:0] state;
  logic       last_served;
  logic       pick1;
  logic       zero_len;
  logic       in_busy;
  logic       fin_evt;
  logic       end_evt;
  logic       err_evt;
  logic       wd_expire;

  assign zero_len = (write_size == 32'd0);
  assign in_busy  = (state == S_BUSY);
  assign busy     = (state != S_IDLE);

  // On a tie, the requester that was not served last wins.
  always_comb begin
    pick1 = req1;
    if (req0 && req1)
      pick1 = ~last_served;
  end

  assign fin_evt = in_busy & write_finished;
  assign end_evt = fin_evt | ((state == S_START) & zero_len) | (state == S_ABORT);
  assign err_evt = (fin_evt & xmit_error) | ((state == S_START) & zero_len) | (state == S_ABORT);

  assign write_start = (state == S_START) & ~zero_len;
  assign write_data  = grant[1] ? data1 : (grant[0] ? data0 : 32'd0);
  assign strobe0     = in_busy & write_strobe & grant[0];
  assign strobe1     = in_busy & write_strobe & grant[1];
  assign done0       = end_evt & grant[0];
  assign done1       = end_evt & grant[1];
  assign err0        = err_evt & grant[0];
  assign err1        = err_evt & grant[1];

`ifdef SATA_WR_ARB_WATCHDOG_EN
  logic [31:0] wd_cnt;

  always_ff @(posedge clk) begin
    if (!rst)
      wd_cnt <= 32'd0;
    else if (!in_busy || write_strobe)
      wd_cnt <= 32'd0;
    else
      wd_cnt <= wd_cnt + 32'd1;
  end

  // Expires on the cycle the count would reach the limit; a finish in that cycle wins.
  assign wd_expire        = in_busy & ~write_strobe & (wd_cnt + 32'd1 == WATCHDOG_CYCLES);
  assign send_sync_escape = (state == S_ABORT);
`else
  logic unused_wd_cfg;
  assign unused_wd_cfg    = ^WATCHDOG_CYCLES;
  assign wd_expire        = 1'b0;
  assign send_sync_escape = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_IDLE;
      grant       <= 2'b00;
      write_size  <= 32'd0;
      last_served <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (link_idle && (req0 || req1)) begin
            grant      <= pick1 ? 2'b10 : 2'b01;
            write_size <= {8'h00, (pick1 ? size1 : size0)};
            state      <= S_START;
          end
        end
        S_START: begin
          if (zero_len) begin
            grant       <= 2'b00;
            last_served <= grant[1];
            state       <= S_IDLE;
          end else begin
            state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (write_finished)
            state <= S_DONE;
          else if (wd_expire)
            state <= S_ABORT;
        end
        S_DONE, S_ABORT: begin
          grant       <= 2'b00;
          last_served <= grant[1];
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sata_link_write_arbiter.sv
// tb/tb_sata_link_write_arbiter.sv - directed self-checking bench for sata_link_write_arbiter
module tb_sata_link_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1;
  logic [23:0] size0, size1;
  logic [31:0] data0, data1;
  logic        strobe0, strobe1, done0, done1, err0, err1;
  logic [1:0]  grant;
  logic        busy;
  logic        link_idle;
  logic        write_start;
  logic [31:0] write_size;
  logic [31:0] write_data;
  logic        write_strobe, write_finished, xmit_error;
  logic        send_sync_escape;

  int n_tests = 0;
  int n_fail  = 0;

  sata_link_write_arbiter #(.WATCHDOG_CYCLES(32'd16)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .size0(size0), .size1(size1),
    .data0(data0), .data1(data1),
    .strobe0(strobe0), .strobe1(strobe1),
    .done0(done0), .done1(done1), .err0(err0), .err1(err1),
    .grant(grant), .busy(busy),
    .link_idle(link_idle), .write_start(write_start), .write_size(write_size),
    .write_data(write_data), .write_strobe(write_strobe),
    .write_finished(write_finished), .xmit_error(xmit_error),
    .send_sync_escape(send_sync_escape)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one frame from IDLE: grant, START, n strobes, finish, DONE.
  task automatic serve(input logic [1:0] g, input int n, input logic xerr, input logic drop);
    tick();
    check_eq("grant", {30'd0, grant}, {30'd0, g});
    check_eq("write_start", {31'd0, write_start}, 32'd1);
    check_eq("write_size", write_size, n);
    if (drop) begin
      req0 = 1'b0;
      req1 = 1'b0;
    end
    tick();
    check_eq("start_one_cycle", {31'd0, write_start}, 32'd0);
    for (int i = 0; i < n; i++) begin
      data0 = 32'h1000 + i;
      data1 = 32'h2000 + i;
      write_strobe = 1'b1;
      #1;
      check_eq("strobe", {30'd0, strobe1, strobe0}, {30'd0, g});
      check_eq("write_data", write_data, g[1] ? 32'h2000 + i : 32'h1000 + i);
      tick();
    end
    write_strobe   = 1'b0;
    write_finished = 1'b1;
    xmit_error     = xerr;
    #1;
    check_eq("done", {30'd0, done1, done0}, {30'd0, g});
    check_eq("err", {30'd0, err1, err0}, xerr ? {30'd0, g} : 32'd0);
    tick();
    write_finished = 1'b0;
    xmit_error     = 1'b0;
    check_eq("done_state_no_pulse", {30'd0, done1, done0}, 32'd0);
    check_eq("done_state_busy", {31'd0, busy}, 32'd1);
    tick();
    check_eq("grant_cleared", {30'd0, grant}, 32'd0);
  endtask

  initial begin
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0; size0 = '0; size1 = '0;
    data0 = '0; data1 = '0; link_idle = 1'b1;
    write_strobe = 1'b0; write_finished = 1'b0; xmit_error = 1'b0;
    tick();
    tick();
    check_eq("rst_grant", {30'd0, grant}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_write_start", {31'd0, write_start}, 32'd0);
    check_eq("rst_write_size", write_size, 32'd0);
    check_eq("rst_sse", {31'd0, send_sync_escape}, 32'd0);
    check_eq("rst_done_err", {28'd0, done1, done0, err1, err0}, 32'd0);
    rst = 1'b1;

    // No grant while the link is not idle
    link_idle = 1'b0; req0 = 1'b1; size0 = 24'd3;
    tick();
    tick();
    check_eq("hold_no_link_idle", {30'd0, grant}, 32'd0);
    link_idle = 1'b1;
    tick();
    check_eq("grant_after_link_idle", {30'd0, grant}, 32'd1);
    tick();
    check_eq("in_busy", {31'd0, busy}, 32'd1);

    // Reset mid-frame with a finish pending: no done, outputs back to reset values
    write_finished = 1'b1;
    rst = 1'b0;
    tick();
    check_eq("midrst_grant", {30'd0, grant}, 32'd0);
    check_eq("midrst_busy", {31'd0, busy}, 32'd0);
    check_eq("midrst_size", write_size, 32'd0);
    check_eq("midrst_done", {30'd0, done1, done0}, 32'd0);
    rst = 1'b1; req0 = 1'b0;
    tick();
    check_eq("finish_outside_busy", {30'd0, done1, done0}, 32'd0);
    write_finished = 1'b0;

    // Single 4-dword frame; requester drops req after grant
    req0 = 1'b1; size0 = 24'd4;
    serve(2'b01, 4, 1'b0, 1'b1);

    // Fresh reset, then tie: 0, 1, 0
    rst = 1'b0;
    tick();
    rst = 1'b1;
    req0 = 1'b1; req1 = 1'b1; size0 = 24'd2; size1 = 24'd3;
    serve(2'b01, 2, 1'b0, 1'b0);
    serve(2'b10, 3, 1'b0, 1'b0);
    serve(2'b01, 2, 1'b0, 1'b1);

    // Zero-length frame
    req1 = 1'b1; size1 = 24'd0;
    tick();
    check_eq("zero_grant", {30'd0, grant}, 32'd2);
    check_eq("zero_no_start", {31'd0, write_start}, 32'd0);
    check_eq("zero_done", {30'd0, done1, done0}, 32'd2);
    check_eq("zero_err", {30'd0, err1, err0}, 32'd2);
    req1 = 1'b0;
    tick();
    check_eq("zero_grant_clear", {30'd0, grant}, 32'd0);
    check_eq("zero_idle", {31'd0, busy}, 32'd0);

    // Transmit error reported with done
    req0 = 1'b1; size0 = 24'd1;
    serve(2'b01, 1, 1'b1, 1'b1);

    // After requester 0 served, a tie goes to requester 1
    req0 = 1'b1; req1 = 1'b1; size1 = 24'd1;
    serve(2'b10, 1, 1'b0, 1'b1);

`ifdef SATA_WR_ARB_WATCHDOG_EN
    req0 = 1'b1; size0 = 24'd5;
    tick();
    req0 = 1'b0;
    tick();
    for (int i = 0; i < 15; i++) tick();
    check_eq("wd_not_yet", {31'd0, send_sync_escape}, 32'd0);
    check_eq("wd_still_busy", {31'd0, busy}, 32'd1);
    tick();
    check_eq("wd_sse", {31'd0, send_sync_escape}, 32'd1);
    check_eq("wd_done", {30'd0, done1, done0}, 32'd1);
    check_eq("wd_err", {30'd0, err1, err0}, 32'd1);
    tick();
    check_eq("wd_sse_off", {31'd0, send_sync_escape}, 32'd0);
    check_eq("wd_idle", {31'd0, busy}, 32'd0);
    check_eq("wd_grant_clear", {30'd0, grant}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
